// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// instruction_fetch_stage : program counter and IF/ID register of the MIPS core
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0040_0000,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Stall_i,
  input  logic                   Flush_i,
  input  logic                   Redirect_i,
  input  logic [DATA_WIDTH-1:0]  RedirectTarget_i,
  input  logic                   Halt_i,
  input  logic [DATA_WIDTH-1:0]  Instruction_i,
  output logic [DATA_WIDTH-1:0]  PC_o,
  output logic [DATA_WIDTH-1:0]  IFID_Instruction_o,
  output logic [DATA_WIDTH-1:0]  IFID_PCPlus4_o,
  output logic                   IFID_Valid_o,
  output logic                   Halted_o,
  output logic [COUNT_WIDTH-1:0] FetchCount_o
);

  localparam logic [DATA_WIDTH-1:0]  PC_STEP    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0]  ALIGN_MASK = ~DATA_WIDTH'(3);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [DATA_WIDTH-1:0]  pc, pc_next;
  logic [DATA_WIDTH-1:0]  ifid_instr, ifid_instr_next;
  logic [DATA_WIDTH-1:0]  ifid_pcp4, ifid_pcp4_next;
  logic                   ifid_valid, ifid_valid_next;
  logic [COUNT_WIDTH-1:0] fetch_count, fetch_count_next;
  logic [DATA_WIDTH-1:0]  pc_plus4;
  logic                   load_bubble;

  assign pc_plus4 = pc + PC_STEP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      ifid_instr  <= '0;
      ifid_pcp4   <= '0;
      ifid_valid  <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      ifid_instr  <= ifid_instr_next;
      ifid_pcp4   <= ifid_pcp4_next;
      ifid_valid  <= ifid_valid_next;
      fetch_count <= fetch_count_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    ifid_instr_next  = ifid_instr;
    ifid_pcp4_next   = ifid_pcp4;
    ifid_valid_next  = ifid_valid;
    fetch_count_next = fetch_count;
    load_bubble      = 1'b0;

    case (state)
      BOOT: begin
        load_bubble = 1'b1;
        state_next  = RUN;
      end
      RUN: begin
        if (Halt_i) begin
          load_bubble = 1'b1;
          state_next  = HALT;
        end else if (Redirect_i) begin
          // Masking keeps the PC word-aligned whatever the target's low bits are.
          pc_next     = RedirectTarget_i & ALIGN_MASK;
          load_bubble = 1'b1;
        end else if (Stall_i) begin
          load_bubble = Flush_i;
        end else if (Flush_i) begin
          pc_next     = pc_plus4;
          load_bubble = 1'b1;
        end else begin
          pc_next          = pc_plus4;
          ifid_instr_next  = Instruction_i;
          ifid_pcp4_next   = pc_plus4;
          ifid_valid_next  = 1'b1;
          fetch_count_next = fetch_count + COUNT_ONE;
        end
      end
      HALT: begin
        load_bubble = 1'b1;
      end
      default: begin
        load_bubble = 1'b1;
        state_next  = BOOT;
      end
    endcase

    if (load_bubble) begin
      ifid_instr_next = '0;
      ifid_pcp4_next  = '0;
      ifid_valid_next = 1'b0;
    end
  end

  assign PC_o               = pc;
  assign IFID_Instruction_o = ifid_instr;
  assign IFID_PCPlus4_o     = ifid_pcp4;
  assign IFID_Valid_o       = ifid_valid;
  assign Halted_o           = (state == HALT);
  assign FetchCount_o       = fetch_count;

endmodule

`default_nettype wire

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Upstream/downstream neighbour of the program memory: owns the program counter and the IF/ID pipeline register of the pipelined MIPS core.
- Drives the fetch address into the program memory and captures the returned instruction into IF/ID.
- Applies stall, flush, redirect and halt requests from the hazard and control units.

Parameters:
DATA_WIDTH, 32, width of PC, instruction and IF/ID fields
RESET_PC, 32'h0040_0000, PC value loaded on reset
COUNT_WIDTH, 16, width of fetch counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
Stall_i  input  1  hazard unit: hold PC and IF/ID
Flush_i  input  1  replace the IF/ID capture with a bubble
Redirect_i  input  1  branch/jump/jr taken; load new PC
RedirectTarget_i  input  DATA_WIDTH  redirect target address
Halt_i  input  1  control: stop fetching until reset
Instruction_i  input  DATA_WIDTH  instruction from program memory (combinational on PC_o)
PC_o  output  DATA_WIDTH  current fetch address to program memory
IFID_Instruction_o  output  DATA_WIDTH  registered instruction to decode
IFID_PCPlus4_o  output  DATA_WIDTH  registered PC+4 of that instruction
IFID_Valid_o  output  1  1 = IF/ID holds a real instruction
Halted_o  output  1  1 in HALT state
FetchCount_o  output  COUNT_WIDTH  number of valid instructions captured into IF/ID

Behaviour:
- Reset (reset==0, asynchronous): PC_o=RESET_PC; IFID_Instruction_o=0; IFID_PCPlus4_o=0; IFID_Valid_o=0; Halted_o=0; FetchCount_o=0; state=BOOT.
- Bubble: Instruction=32'h0000_0000 (nop), PCPlus4=0, Valid=0.
- State BOOT: lasts exactly one rising edge after reset release. PC holds and IF/ID loads a bubble. All inputs are ignored. Next state is RUN.
- State RUN: evaluate on each rising edge in this priority order.
  1. Halt_i=1: PC holds; IF/ID loads a bubble; next state is HALT.
  2. Redirect_i=1: PC <= {RedirectTarget_i[31:2],2'b00}; IF/ID loads a bubble (discards the wrong-path fetch). Stall_i and Flush_i are ignored that cycle.
  3. Stall_i=1: PC holds; IF/ID holds its contents, except when Flush_i=1, in which case IF/ID loads a bubble.
  4. Flush_i=1 (no stall): PC <= PC+4; IF/ID loads a bubble.
  5. Otherwise: PC <= PC+4; IFID_Instruction_o <= Instruction_i; IFID_PCPlus4_o <= PC+4; IFID_Valid_o <= 1; FetchCount_o increments.
- State HALT: Halted_o=1. PC is frozen and IF/ID loads a bubble every cycle. All inputs are ignored. The only exit is reset.
- Arithmetic:
  - PC+4 is computed modulo 2^DATA_WIDTH (0xFFFF_FFFC -> 0x0000_0000).
  - FetchCount_o wraps modulo 2^COUNT_WIDTH.
  - PC[1:0] is always 00.
- Latency: an instruction at address A appears on IF/ID one edge after PC_o==A, provided there is no stall, flush or redirect.
- Combinational path: the Instruction_i -> IF/ID capture path has no combinational loop back to PC_o.
- Reset mid-operation: asynchronously forces all reset values regardless of state, including HALT, and returns to BOOT.

Test Plan:
- Reset, release, 4 edges, memory returns 0x20080005 @0x400000, 0x20090003 @0x400004 -> BOOT edge gives bubble with PC 0x400000; then IF/ID=0x20080005/PCPlus4 0x400004/Valid=1, then 0x20090003/0x400008; FetchCount_o=2 after the second capture.
- Stall_i=1 for 2 cycles after IF/ID holds 0x20090003 -> PC_o stays 0x400008 and IF/ID unchanged for both edges; FetchCount_o unchanged; fetch resumes at 0x400008.
- Redirect_i=1, target 0x00400023, with Stall_i=1 the same cycle -> PC_o=0x00400020 and IF/ID bubble (Valid=0); next edge captures the instruction at 0x400020.
- Flush_i=1 with Stall_i=1, then Flush_i=1 alone -> first edge: bubble, PC held; second edge: bubble, PC+4.
- Halt_i=1 at PC 0x40000C -> Halted_o=1; PC frozen at 0x40000C; Valid=0 for 10 cycles despite Redirect_i pulses; reset then restores PC 0x400000 and Halted_o=0.
- PC forced near the top via redirect to 0xFFFFFFFC, one normal fetch -> PC_o=0x00000000, IFID_PCPlus4_o=0x00000000, Valid=1; assert reset mid-cycle -> outputs change immediately, before the next edge.
